sprite_motion_animator: RTL
===========================

Name: sprite_motion_animator

Overview:
- Next-generation player-sprite controller: keyboard-driven left/right motion with parametrised position bounds, a multi-frame walk animation for each facing direction, and an optional gravity jump.
- Updates once per frame_clk edge (vertical sync).
- Drives the sprite ROM select (sel) and the sprite's top-left position (spritex/spritey) for the sprite renderer.

Parameters:
X_START, 290, reset X position (left edge, pixels)
Y_START, 350, reset Y position; also the ground line for landing
X_MIN, 0, minimum X position
X_MAX, 607, maximum X position (639 minus sprite width)
X_STEP, 1, pixels moved per frame while a direction key is held
NUM_FRAMES, 4, walk-animation frames per direction (power of 2, 2..8)
FRAME_HOLD, 8, frame_clk ticks each animation frame is shown (1..255)
SEL_RIGHT_BASE, 8, sel value of right-facing frame 0
SEL_LEFT_BASE, 12, sel value of left-facing frame 0
JUMP_V0, 12, initial upward speed in pixels/frame (SPRITE_JUMP_EN only)
GRAVITY, 1, added to vertical speed each airborne tick (SPRITE_JUMP_EN only)

Ports:
frame_clk  input  1  sole clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Keycode  input  8  current keycode: 79 = right, 80 = left, 82 = up; any other value = no key
sel  output  4  registered sprite select
spritex  output  10  registered X position
spritey  output  10  registered Y position
facing_left  output  1  registered; 1 = facing left
moving  output  1  registered; 1 when state is WALK or AIR

Behaviour:
- Single clock, synchronous active-high reset. All outputs are registered and change only on frame_clk rising edges.
- Reset (sampled at an edge, including mid-jump or mid-walk) sets:
  - spritex=X_START, spritey=Y_START
  - state IDLE, facing_left=0, moving=0
  - frame index=0, hold counter=0, vertical speed=0
  - sel=SEL_RIGHT_BASE
- States: IDLE, WALK, AIR (AIR exists only with the macro).
- Horizontal motion (IDLE/WALK/AIR), applied on the same edge the key is sampled:
  - Keycode 79: x = min(x+X_STEP, X_MAX); facing_left=0.
  - Keycode 80: x = max(x-X_STEP, X_MIN). Compute without wrap: if x < X_MIN+X_STEP, x=X_MIN.
  - Any other keycode: x unchanged.
- IDLE:
  - 79/80 -> WALK; frame index=0, hold=0.
  - 82 -> AIR (macro only).
  - Otherwise stay.
  - sel = facing base + 0.
- WALK:
  - 79/80 held -> stay.
  - Hold counter increments each tick. When it equals FRAME_HOLD-1 it wraps to 0 and frame index advances modulo NUM_FRAMES.
  - A direction reversal (79<->80) resets frame and hold to 0 on that edge.
  - 82 -> AIR. Any other keycode -> IDLE (frame and hold reset to 0).
  - sel = facing base + frame index.
  - Reaching a clamp does not stop the animation (walking against the wall).
- Base selection: facing_left=0 uses SEL_RIGHT_BASE; facing_left=1 uses SEL_LEFT_BASE.
- sel, facing_left and moving reflect the post-edge state.

Optional Feature:
Macro: SPRITE_JUMP_EN
- Defined:
  - Launch edge: the AIR state is entered; vy = -JUMP_V0 (signed, 11 bit); y unchanged.
  - Each subsequent AIR tick: y = y+vy, then vy = vy+GRAVITY.
  - If y+vy < 0: y=0, vy=0 (ceiling).
  - Landing: if y+vy >= Y_START, then y=Y_START, vy=0, and the next state is WALK if Keycode is 79/80 on that edge, else IDLE. Frame and hold reset to 0.
  - Keycode 82 while in AIR is ignored (no double jump). Left/right steering is active in AIR.
  - sel in AIR = facing base + (NUM_FRAMES-1).
- Undefined:
  - No AIR state and no vertical speed register.
  - spritey is constant at Y_START after reset.
  - Keycode 82 behaves as "no key".

Test Plan:
- Walk animation: reset, then Keycode=79 for 40 ticks -> spritex=330. sel=8 for ticks 1-8, 9 for ticks 9-16, 10 for 17-24, 11 for 25-32, 8 for 33-40. moving=1. Release key -> next edge sel=8, moving=0.
- Right clamp: reset, then Keycode=79 for 400 ticks -> spritex saturates at 607 by tick 317 and stays there. No wrap; animation keeps cycling.
- Left clamp and facing: reset, then Keycode=80 for 300 ticks -> spritex=0 (never 1023). facing_left=1; sel walks 12..15. Release -> sel=12.
- Reversal: after 12 ticks of 79 (sel=9), apply 80 for one tick -> sel=12, spritex decrements by 1, facing_left=1.
- Jump (macro defined): reset, then Keycode=82 for one edge, then 0 -> spritey goes 338, 327, ..., minimum 272 at AIR tick 12, back to 350 at AIR tick 25. Then state IDLE, sel=8. Sending 82 mid-air has no effect. Macro undefined: 82 leaves spritey=350 and sel=8.
- Reset mid-operation: assert Reset at AIR tick 5 (or at WALK tick 20) -> on that edge spritex=290, spritey=350, sel=8, facing_left=0, moving=0. The next 79 restarts the animation at frame 0.

Source files
------------

// File: rtl/sprite_motion_animator.sv
// sprite_motion_animator
//
// Player-sprite controller. Once per frame_clk rising edge (vertical sync) it reads
// the current keycode, moves the sprite left or right inside [X_MIN, X_MAX],
// advances a per-direction walk animation and, when SPRITE_JUMP_EN is defined,
// runs a simple gravity jump.
//
// Optional feature macro: SPRITE_JUMP_EN
//   defined   - keycode 82 launches a jump (AIR state, vertical speed register)
//   undefined - no AIR state, spritey stays at Y_START, keycode 82 acts as no key
//
// Ports:
//   frame_clk   in   1   sole clock, all state changes on its rising edge
//   Reset       in   1   synchronous active-high reset
//   Keycode     in   8   79 = right, 80 = left, 82 = up, anything else = no key
//   sel         out  4   registered sprite ROM select
//   spritex     out  10  registered top-left X position
//   spritey     out  10  registered top-left Y position
//   facing_left out  1   registered, 1 = facing left
//   moving      out  1   registered, 1 while walking or airborne

module sprite_motion_animator #(
  parameter int X_START        = 290,
  parameter int Y_START        = 350,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 607,
  parameter int X_STEP         = 1,
  parameter int NUM_FRAMES     = 4,
  parameter int FRAME_HOLD     = 8,
  parameter int SEL_RIGHT_BASE = 8,
  parameter int SEL_LEFT_BASE  = 12,
  parameter int JUMP_V0        = 12,
  parameter int GRAVITY        = 1
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] Keycode,
  output logic [3:0] sel,
  output logic [9:0] spritex,
  output logic [9:0] spritey,
  output logic       facing_left,
  output logic       moving
);

  localparam int FW = $clog2(NUM_FRAMES);

`ifdef SPRITE_JUMP_EN
  typedef enum logic [1:0] {IDLE, WALK, AIR} state_t;
  localparam logic signed [11:0] Y_GROUND = 12'(Y_START);
`else
  typedef enum logic [1:0] {IDLE, WALK} state_t;
`endif

  state_t         state, state_next;
  logic [FW-1:0]  frame, frame_next;
  logic [7:0]     hold, hold_next;
  logic [9:0]     x_next, y_next;
  logic [10:0]    x_plus;
  logic           face_next;
  logic           key_right, key_left, key_dir, reversal;
  logic [3:0]     sel_next;

`ifdef SPRITE_JUMP_EN
  logic               key_up;
  logic signed [10:0] vy, vy_next;
  logic signed [11:0] y_sum;
`endif

  assign key_right = (Keycode == 8'd79);
  assign key_left  = (Keycode == 8'd80);
  assign key_dir   = key_right | key_left;
`ifdef SPRITE_JUMP_EN
  assign key_up    = (Keycode == 8'd82);
`endif

  // Horizontal motion runs in every state. Both clamps are evaluated on widened or
  // pre-checked values so the position can never wrap through 0 or 1023.
  always_comb begin
    x_plus    = {1'b0, spritex} + 11'(X_STEP);
    x_next    = spritex;
    face_next = facing_left;
    if (key_right) begin
      x_next    = (x_plus > 11'(X_MAX)) ? 10'(X_MAX) : x_plus[9:0];
      face_next = 1'b0;
    end else if (key_left) begin
      x_next    = ({1'b0, spritex} < 11'(X_MIN + X_STEP)) ? 10'(X_MIN) : spritex - 10'(X_STEP);
      face_next = 1'b1;
    end
  end

  // While walking a key is always held, so a change of facing means the player
  // reversed direction and the cycle should restart from frame 0.
  assign reversal = (face_next != facing_left);

  // Next-state logic for the animation / jump state machine.
  always_comb begin
    state_next = state;
    frame_next = frame;
    hold_next  = hold;
    y_next     = spritey;
`ifdef SPRITE_JUMP_EN
    vy_next    = vy;
    y_sum      = $signed({2'b00, spritey}) + $signed({vy[10], vy});
`endif
    case (state)
      IDLE: begin
        frame_next = '0;
        hold_next  = '0;
        if (key_dir) begin
          state_next = WALK;
`ifdef SPRITE_JUMP_EN
        end else if (key_up) begin
          state_next = AIR;
          vy_next    = 11'(-JUMP_V0);
`endif
        end
      end
      WALK: begin
        if (key_dir) begin
          if (reversal) begin
            frame_next = '0;
            hold_next  = '0;
          end else if (hold == 8'(FRAME_HOLD - 1)) begin
            hold_next  = '0;
            frame_next = (frame == FW'(NUM_FRAMES - 1)) ? '0 : frame + 1'b1;
          end else begin
            hold_next  = hold + 8'd1;
          end
`ifdef SPRITE_JUMP_EN
        end else if (key_up) begin
          state_next = AIR;
          vy_next    = 11'(-JUMP_V0);
          frame_next = '0;
          hold_next  = '0;
`endif
        end else begin
          state_next = IDLE;
          frame_next = '0;
          hold_next  = '0;
        end
      end
`ifdef SPRITE_JUMP_EN
      // Airborne: ceiling clamp first, then landing on the ground line; a held
      // direction key on the landing edge drops straight back into WALK.
      AIR: begin
        frame_next = '0;
        hold_next  = '0;
        if (y_sum < 12'sd0) begin
          y_next  = '0;
          vy_next = '0;
        end else if (y_sum >= Y_GROUND) begin
          y_next     = 10'(Y_START);
          vy_next    = '0;
          state_next = key_dir ? WALK : IDLE;
        end else begin
          y_next  = y_sum[9:0];
          vy_next = vy + 11'(GRAVITY);
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // The airborne pose is always the last animation frame of the current facing.
  always_comb begin
    sel_next = face_next ? 4'(SEL_LEFT_BASE) : 4'(SEL_RIGHT_BASE);
`ifdef SPRITE_JUMP_EN
    if (state_next == AIR)
      sel_next = sel_next + 4'(NUM_FRAMES - 1);
    else
`endif
      sel_next = sel_next + 4'(frame_next);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state       <= IDLE;
      frame       <= '0;
      hold        <= '0;
      spritex     <= 10'(X_START);
      spritey     <= 10'(Y_START);
      facing_left <= 1'b0;
      moving      <= 1'b0;
      sel         <= 4'(SEL_RIGHT_BASE);
`ifdef SPRITE_JUMP_EN
      vy          <= '0;
`endif
    end else begin
      state       <= state_next;
      frame       <= frame_next;
      hold        <= hold_next;
      spritex     <= x_next;
      spritey     <= y_next;
      facing_left <= face_next;
      moving      <= (state_next != IDLE);
      sel         <= sel_next;
`ifdef SPRITE_JUMP_EN
      vy          <= vy_next;
`endif
    end
  end

endmodule
